lmu_measfb_apply: RTL and testbench

Consumes the per-cycle measurement-feedback code that the LMU interpreter emits, buffers it, and turns it into a registered byproduct-update vector for a conditional instruction's target logical qubit. The block sits between the LMU feedback output and the byproduct accumulation path. Each cond request from the instruction decoder pairs, in order, with the oldest buffered feedback. It delivers `NUM_LQ*2`-bit updates with exactly one non-I Pauli at the target index, ready to be XORed into the byproduct register.

---
 rtl/lmu_measfb_apply_pkg.sv | 31 +++
 rtl/lmu_measfb_apply_fifo.sv | 78 +++++++
 rtl/lmu_measfb_apply.sv | 122 ++++++++++++
 tb/tb_lmu_measfb_apply.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmu_measfb_apply_pkg.sv
// Shared encodings for the LMU measurement-feedback apply block: Pauli codes,
// feedback codes and the local FSM state type.
package lmu_measfb_apply_pkg;

  localparam int NUM_LQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    PP_I = 2'b00,
    PP_X = 2'b01,
    PP_Z = 2'b10,
    PP_Y = 2'b11
  } pauli_e;

  typedef enum logic [1:0] {
    FBXORZ_INVALID = 2'b00,
    FBXORZ_X       = 2'b01,
    FBXORZ_Z       = 2'b10
  } fbxorz_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FB = 2'd1,
    ST_ISSUE   = 2'd2
  } state_e;

  // A buffered entry of 1 means the LMU asked for a Z correction, 0 for X.
  function automatic pauli_e fbToPauli(input logic isZ);
    return isZ ? PP_Z : PP_X;
  endfunction

endpackage

// File: rtl/lmu_measfb_apply_fifo.sv
// One-bit-wide feedback FIFO with wrapping pointers and an explicit occupancy
// counter, so full and empty never need a spare pointer bit.
module measfb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pushData_i,
  input  logic                     pop_i,
  output logic                     head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);
  assign drop_o = push_i && full_o && !doPop && !flush_i;

  always_comb begin
    mem_d   = mem_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) begin
        mem_d[wrPtr_q] = pushData_i;
        wrPtr_d        = wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lmu_measfb_apply.sv
// Pairs each conditional request, in order, with the oldest buffered LMU
// feedback bit and issues a registered single-Pauli byproduct update.
module lmu_measfb_apply
  import lmu_measfb_apply_pkg::*;
#(
  parameter int NUM_LQ   = NUM_LQ_DEFAULT,
  parameter int LQ_W     = $clog2(NUM_LQ),
  parameter int FB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 measfb_xorz,
  input  logic                       cond_valid,
  input  logic [LQ_W-1:0]            cond_lq,
  output logic                       cond_ready,
  output logic                       bp_valid,
  output logic [NUM_LQ*2-1:0]        bp_update,
  input  logic                       bp_ready,
  input  logic                       flush,
  output logic [$clog2(FB_DEPTH):0]  fb_count,
  output logic                       fb_full,
  output logic                       overflow_err
);

  state_e              state_q, state_d;
  logic [LQ_W-1:0]     targetLq_q, targetLq_d;
  logic [NUM_LQ*2-1:0] bpUpdate_q, bpUpdate_d;
  logic                overflow_q, overflow_d;

  logic fbPush;
  logic fbPushZ;
  logic fbPop;
  logic fbHead;
  logic fbEmpty;
  logic fbDrop;

  assign fbPush  = (measfb_xorz == FBXORZ_X) || (measfb_xorz == FBXORZ_Z);
  assign fbPushZ = (measfb_xorz == FBXORZ_Z);

  measfb_fifo #(
    .DEPTH (FB_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .push_i     (fbPush),
    .pushData_i (fbPushZ),
    .pop_i      (fbPop),
    .head_o     (fbHead),
    .count_o    (fb_count),
    .full_o     (fb_full),
    .empty_o    (fbEmpty),
    .drop_o     (fbDrop)
  );

  // Out-of-range targets match no field and yield an all-identity update.
  function automatic logic [NUM_LQ*2-1:0] buildUpdate(input logic [LQ_W-1:0] lq,
                                                      input logic isZ);
    logic [NUM_LQ*2-1:0] vec;
    vec = '0;
    for (int i = 0; i < NUM_LQ; i++) begin
      if (int'(lq) == i) begin
        vec[i*2 +: 2] = fbToPauli(isZ);
      end
    end
    return vec;
  endfunction

  always_comb begin
    state_d    = state_q;
    targetLq_d = targetLq_q;
    bpUpdate_d = bpUpdate_q;
    fbPop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cond_valid) begin
          targetLq_d = cond_lq;
          state_d    = ST_WAIT_FB;
        end
      end
      ST_WAIT_FB: begin
        if (!fbEmpty) begin
          fbPop      = 1'b1;
          bpUpdate_d = buildUpdate(targetLq_q, fbHead);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      fbPop   = 1'b0;
    end
  end

  assign overflow_d = flush ? 1'b0 : (overflow_q | fbDrop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      targetLq_q <= '0;
      bpUpdate_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      targetLq_q <= targetLq_d;
      bpUpdate_q <= bpUpdate_d;
      overflow_q <= overflow_d;
    end
  end

  assign cond_ready   = (state_q == ST_IDLE);
  assign bp_valid     = (state_q == ST_ISSUE);
  assign bp_update    = bpUpdate_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_lmu_measfb_apply.sv
// Scoreboard bench for lmu_measfb_apply: directed scenarios plus a randomized
// phase, all checked against an in-order feedback/cond pairing model.
module tb_lmu_measfb_apply;
  import lmu_measfb_apply_pkg::*;

  localparam int NUM_LQ   = 4;
  localparam int LQ_W     = 2;
  localparam int FB_DEPTH = 4;

  logic                clk;
  logic                rst_n;
  logic [1:0]          measfb_xorz;
  logic                cond_valid;
  logic [LQ_W-1:0]     cond_lq;
  logic                cond_ready;
  logic                bp_valid;
  logic [NUM_LQ*2-1:0] bp_update;
  logic                bp_ready;
  logic                flush;
  logic [2:0]          fb_count;
  logic                fb_full;
  logic                overflow_err;

  int passCount  = 0;
  int checkCount = 0;

  bit                  fbQ[$];
  int                  condQ[$];
  logic [NUM_LQ*2-1:0] scoreQ[$];

  lmu_measfb_apply #(
    .NUM_LQ   (NUM_LQ),
    .LQ_W     (LQ_W),
    .FB_DEPTH (FB_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .measfb_xorz  (measfb_xorz),
    .cond_valid   (cond_valid),
    .cond_lq      (cond_lq),
    .cond_ready   (cond_ready),
    .bp_valid     (bp_valid),
    .bp_update    (bp_update),
    .bp_ready     (bp_ready),
    .flush        (flush),
    .fb_count     (fb_count),
    .fb_full      (fb_full),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference model: the n-th accepted cond always pairs with the n-th
  // accepted feedback, independent of when either arrived.
  function automatic void modelPair();
    int lq;
    bit isZ;
    logic [NUM_LQ*2-1:0] exp;
    while (fbQ.size() > 0 && condQ.size() > 0) begin
      lq  = condQ.pop_front();
      isZ = fbQ.pop_front();
      exp = '0;
      if (lq < NUM_LQ) exp[lq*2 +: 2] = isZ ? 2'b10 : 2'b01;
      scoreQ.push_back(exp);
    end
  endfunction

  function automatic void modelPushFb(input bit isZ);
    fbQ.push_back(isZ);
    modelPair();
  endfunction

  function automatic void modelCond(input int lq);
    condQ.push_back(lq);
    modelPair();
  endfunction

  function automatic void modelClear();
    fbQ.delete();
    condQ.delete();
    scoreQ.delete();
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Feedback and cond are one-cycle pulses; bp_ready stays as driven.
  task automatic applyStimulus(input logic [1:0] xorz, input logic cv,
                               input logic [LQ_W-1:0] lq, input logic br);
    measfb_xorz = xorz;
    cond_valid  = cv;
    cond_lq     = lq;
    bp_ready    = br;
    tick();
    measfb_xorz = FBXORZ_INVALID;
    cond_valid  = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!bp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bp_valid) begin
      checkCount++;
      $display("[TB] FAIL %s: bp_valid timeout got 0, expected 1", name);
    end
  endtask

  task automatic waitCondReady(input string name);
    int n = 0;
    while (!cond_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cond_ready) begin
      checkCount++;
      $display("[TB] FAIL %s: cond_ready timeout got 0, expected 1", name);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks that a
  // stalled update is held stable.
  bit                  prevValid = 0;
  bit                  prevReady = 0;
  bit                  prevFlush = 0;
  logic [NUM_LQ*2-1:0] prevUpdate = '0;

  always begin
    logic [NUM_LQ*2-1:0] exp;
    @(negedge clk);
    #1;
    if (!rst_n) begin
      prevValid = 0;
    end else begin
      if (bp_valid && prevValid && !prevReady && !prevFlush)
        checkOutput("bp_update_stable", 32'(bp_update), 32'(prevUpdate));
      if (bp_valid && bp_ready && !flush) begin
        if (scoreQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL bp_unexpected: got update 0x%0h, expected none", bp_update);
        end else begin
          exp = scoreQ.pop_front();
          checkOutput("bp_update_sb", 32'(bp_update), 32'(exp));
        end
      end
      prevValid  = bp_valid;
      prevReady  = bp_ready;
      prevFlush  = flush;
      prevUpdate = bp_update;
    end
  end

  task automatic runRandom(input int nTx);
    int issued = 0;
    int accepted = 0;
    int pushed = 0;
    bit readyAtDrive = 0;
    bit done = 0;
    bit isZ;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      tick();
      if (cond_valid && readyAtDrive) begin
        modelCond(int'(cond_lq));
        accepted++;
        cond_valid = 1'b0;
      end
      if (accepted == nTx && pushed == nTx && scoreQ.size() == 0) begin
        done = 1;
      end else begin
        readyAtDrive = cond_ready;
        if (!cond_valid && issued < nTx && $urandom_range(0, 2) == 0) begin
          cond_valid = 1'b1;
          cond_lq    = LQ_W'($urandom_range(0, NUM_LQ - 1));
          issued++;
        end
        if (pushed < nTx && (pushed - accepted) <= FB_DEPTH - 2 && $urandom_range(0, 1) == 1) begin
          isZ = 1'($urandom_range(0, 1));
          measfb_xorz = isZ ? FBXORZ_Z : FBXORZ_X;
          modelPushFb(isZ);
          pushed++;
        end else begin
          measfb_xorz = FBXORZ_INVALID;
        end
        bp_ready = ($urandom_range(0, 3) != 0);
      end
    end
    measfb_xorz = FBXORZ_INVALID;
    cond_valid  = 1'b0;
    bp_ready    = 1'b1;
    if (!done) begin
      checkCount++;
      $display("[TB] FAIL random_drain: accepted %0d pushed %0d, expected %0d each", accepted, pushed, nTx);
    end
  endtask

  logic [NUM_LQ*2-1:0] orderExp[3];
  int                  orderLq[3];
  int                  lqr;

  initial begin
    clk = 0; rst_n = 0; measfb_xorz = FBXORZ_INVALID; cond_valid = 0;
    cond_lq = '0; bp_ready = 0; flush = 0;
    repeat (3) tick();
    checkOutput("reset_cond_ready", 32'(cond_ready), 1);
    checkOutput("reset_bp_valid", 32'(bp_valid), 0);
    checkOutput("reset_bp_update", 32'(bp_update), 0);
    checkOutput("reset_fb_count", 32'(fb_count), 0);
    checkOutput("reset_fb_full", 32'(fb_full), 0);
    checkOutput("reset_overflow", 32'(overflow_err), 0);
    rst_n = 1;
    tick();

    // Feedback buffered before the cond arrives.
    modelPushFb(1);
    applyStimulus(FBXORZ_Z, 0, 0, 1);
    checkOutput("fbfirst_count", 32'(fb_count), 1);
    modelCond(2);
    applyStimulus(FBXORZ_INVALID, 1, 2, 1);
    checkOutput("fbfirst_valid_early", 32'(bp_valid), 0);
    tick();
    checkOutput("fbfirst_valid", 32'(bp_valid), 1);
    checkOutput("fbfirst_update", 32'(bp_update), 32'h20);
    checkOutput("fbfirst_count_after", 32'(fb_count), 0);
    tick();
    checkOutput("fbfirst_idle", 32'(cond_ready), 1);

    // Cond waits on an empty FIFO.
    modelCond(0);
    applyStimulus(FBXORZ_INVALID, 1, 0, 1);
    repeat (5) tick();
    checkOutput("condfirst_wait_valid", 32'(bp_valid), 0);
    checkOutput("condfirst_wait_ready", 32'(cond_ready), 0);
    modelPushFb(0);
    applyStimulus(FBXORZ_X, 0, 0, 1);
    checkOutput("condfirst_valid_early", 32'(bp_valid), 0);
    tick();
    checkOutput("condfirst_valid", 32'(bp_valid), 1);
    checkOutput("condfirst_update", 32'(bp_update), 32'h01);
    tick();

    // Ordering under backpressure.
    modelPushFb(0); applyStimulus(FBXORZ_X, 0, 0, 0);
    modelPushFb(1); applyStimulus(FBXORZ_Z, 0, 0, 0);
    modelPushFb(0); applyStimulus(FBXORZ_X, 0, 0, 0);
    checkOutput("order_count", 32'(fb_count), 3);
    orderLq[0] = 1; orderLq[1] = 1; orderLq[2] = 3;
    orderExp[0] = 8'h04; orderExp[1] = 8'h08; orderExp[2] = 8'h40;
    for (int k = 0; k < 3; k++) begin
      waitCondReady("order_ready");
      modelCond(orderLq[k]);
      applyStimulus(FBXORZ_INVALID, 1, LQ_W'(orderLq[k]), 0);
      waitValid("order_valid");
      checkOutput("order_update", 32'(bp_update), 32'(orderExp[k]));
      repeat (4) tick();
      checkOutput("order_hold", 32'(bp_update), 32'(orderExp[k]));
      bp_ready = 1'b1;
      tick();
      bp_ready = 1'b0;
    end

    // Fill to full, push+pop while full, then a dropped push.
    modelPushFb(0); applyStimulus(FBXORZ_X, 0, 0, 1);
    modelPushFb(1); applyStimulus(FBXORZ_Z, 0, 0, 1);
    modelPushFb(1); applyStimulus(FBXORZ_Z, 0, 0, 1);
    modelPushFb(0); applyStimulus(FBXORZ_X, 0, 0, 1);
    checkOutput("ovf_full", 32'(fb_full), 1);
    checkOutput("ovf_count4", 32'(fb_count), 4);
    checkOutput("ovf_err_none", 32'(overflow_err), 0);
    modelCond(3);
    applyStimulus(FBXORZ_INVALID, 1, 3, 1);
    modelPushFb(0);
    applyStimulus(FBXORZ_X, 0, 0, 1);
    checkOutput("pushpop_count", 32'(fb_count), 4);
    checkOutput("pushpop_err", 32'(overflow_err), 0);
    checkOutput("pushpop_valid", 32'(bp_valid), 1);
    applyStimulus(FBXORZ_Z, 0, 0, 1);
    checkOutput("drop_err", 32'(overflow_err), 1);
    checkOutput("drop_count", 32'(fb_count), 4);
    for (int k = 0; k < 4; k++) begin
      waitCondReady("drain_ready");
      lqr = $urandom_range(0, NUM_LQ - 1);
      modelCond(lqr);
      applyStimulus(FBXORZ_INVALID, 1, LQ_W'(lqr), 1);
      waitValid("drain_valid");
      tick();
    end
    checkOutput("drain_count", 32'(fb_count), 0);
    checkOutput("drain_err_sticky", 32'(overflow_err), 1);

    // Flush while in ISSUE with entries buffered and a push in the same cycle.
    for (int k = 0; k < 4; k++) begin
      modelPushFb(k[0]);
      applyStimulus(k[0] ? FBXORZ_Z : FBXORZ_X, 0, 0, 0);
    end
    modelCond(1);
    applyStimulus(FBXORZ_INVALID, 1, 1, 0);
    waitValid("flush_setup");
    checkOutput("flush_pre_count", 32'(fb_count), 3);
    flush = 1'b1;
    measfb_xorz = FBXORZ_Z;
    modelClear();
    tick();
    flush = 1'b0;
    measfb_xorz = FBXORZ_INVALID;
    checkOutput("flush_count", 32'(fb_count), 0);
    checkOutput("flush_valid", 32'(bp_valid), 0);
    checkOutput("flush_idle", 32'(cond_ready), 1);
    checkOutput("flush_err", 32'(overflow_err), 0);
    checkOutput("flush_full", 32'(fb_full), 0);

    runRandom(60);
    repeat (3) tick();
    checkOutput("scoreboard_drained", 32'(scoreQ.size()), 0);

    // Asynchronous reset in the middle of ISSUE.
    modelPushFb(1);
    applyStimulus(FBXORZ_Z, 0, 0, 0);
    modelCond(3);
    applyStimulus(FBXORZ_INVALID, 1, 3, 0);
    waitValid("reset_setup");
    #2;
    rst_n = 1'b0;
    modelClear();
    #1;
    checkOutput("arst_bp_valid", 32'(bp_valid), 0);
    checkOutput("arst_cond_ready", 32'(cond_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst_bp_valid", 32'(bp_valid), 0);
    checkOutput("rst_cond_ready", 32'(cond_ready), 1);
    checkOutput("rst_fb_count", 32'(fb_count), 0);
    checkOutput("rst_overflow", 32'(overflow_err), 0);
    checkOutput("rst_bp_update", 32'(bp_update), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
